hazard_forward_unit: RTL and testbench

Tracks destination registers of in-flight instructions across the EX, MEM and WB stages of the 5-stage MIPS pipeline. Drives the 2-bit selectors of the two ALU-operand 3-input forwarding muxes and the load-use stall controls. Those controls freeze PC and IF/ID and zero the 12-bit ID/EX control word through the 2-input 12-bit control mux. Sits between decode and the EX-stage operand muxes.

---
 rtl/hazard_forward_unit_pkg.sv | 34 +++
 rtl/hazard_forward_unit_if.sv | 35 +++
 rtl/hazard_forward_unit_fwd_cmp.sv | 21 ++
 rtl/hazard_forward_unit.sv | 86 ++++++++
 tb/tb_hazard_forward_unit.sv | 183 ++++++++++++++++++
 5 files changed

// File: rtl/hazard_forward_unit_pkg.sv
// Shared pipeline definitions for the hazard/forwarding unit: selector codes,
// register-index width and per-stage in-flight records.
package hazard_forward_unit_pkg;
  localparam int REG_W   = 5;
  localparam int NUM_OPS = 2;

  localparam logic [1:0] FWD_NONE  = 2'd0;
  localparam logic [1:0] FWD_EXMEM = 2'd1;
  localparam logic [1:0] FWD_MEMWB = 2'd2;

  typedef logic [REG_W-1:0] reg_idx_t;

  typedef struct packed {
    logic     valid;
    reg_idx_t dest;
    logic     regwrite;
    logic     memread;
  } stage_rec_t;

  typedef struct packed {
    stage_rec_t base;
    reg_idx_t   rs;
    reg_idx_t   rt;
    logic       uses_rs;
    logic       uses_rt;
  } ex_rec_t;

  // True when rec will write src; $0 never counts. block_loads masks loads
  // whose data is not yet available in that stage.
  function automatic logic fwd_hit(stage_rec_t rec, reg_idx_t src, logic block_loads);
    return rec.valid && rec.regwrite && (rec.dest != '0) && (rec.dest == src) &&
           !(block_loads && rec.memread);
  endfunction
endpackage

// File: rtl/hazard_forward_unit_if.sv
// Decode-side bus of the hazard/forwarding unit: ID-stage instruction info in,
// forwarding selectors and stall controls out.
interface hazard_forward_unit_if;
  import hazard_forward_unit_pkg::*;

  logic        id_valid;
  reg_idx_t    id_rs;
  reg_idx_t    id_rt;
  logic        id_uses_rs;
  logic        id_uses_rt;
  reg_idx_t    id_dest;
  logic        id_regwrite;
  logic        id_memread;
  logic        ex_flush;
  logic [1:0]  fwd_a_sel;
  logic [1:0]  fwd_b_sel;
  logic        pc_write_en;
  logic        ifid_write_en;
  logic        ctrl_bubble_sel;
  logic [31:0] stall_cnt;

  modport master (
    output id_valid, id_rs, id_rt, id_uses_rs, id_uses_rt, id_dest,
           id_regwrite, id_memread, ex_flush,
    input  fwd_a_sel, fwd_b_sel, pc_write_en, ifid_write_en,
           ctrl_bubble_sel, stall_cnt
  );

  modport slave (
    input  id_valid, id_rs, id_rt, id_uses_rs, id_uses_rt, id_dest,
           id_regwrite, id_memread, ex_flush,
    output fwd_a_sel, fwd_b_sel, pc_write_en, ifid_write_en,
           ctrl_bubble_sel, stall_cnt
  );
endinterface

// File: rtl/hazard_forward_unit_fwd_cmp.sv
// Per-operand forwarding compare: picks EX/MEM, MEM/WB or register-file data
// for one ALU operand of the instruction currently in EX.
module hfu_fwd_cmp
  import hazard_forward_unit_pkg::*;
(
  input  stage_rec_t mem,
  input  stage_rec_t wb,
  input  reg_idx_t   src,
  input  logic       uses,
  output logic [1:0] sel
);
  // MEM is checked first so the youngest producer wins; a load in MEM has no
  // data yet, so it can only forward once it reaches WB.
  always_comb begin
    sel = FWD_NONE;
    if (uses && fwd_hit(mem, src, 1'b1))
      sel = FWD_EXMEM;
    else if (uses && fwd_hit(wb, src, 1'b0))
      sel = FWD_MEMWB;
  end
endmodule

// File: rtl/hazard_forward_unit.sv
// Hazard detection and forwarding unit for the 5-stage pipeline.
// Optional stall-cycle counter enabled by defining HFU_STALL_CNT_EN.
module hazard_forward_unit
  import hazard_forward_unit_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  hazard_forward_unit_if.slave  bus
);
  ex_rec_t    ex_q, ex_d;
  stage_rec_t mem_q, wb_q;
  logic       stall;
  logic       src_hit;

  reg_idx_t [NUM_OPS-1:0]      op_src;
  logic     [NUM_OPS-1:0]      op_uses;
  logic     [NUM_OPS-1:0][1:0] op_sel;

  // Load-use: the ID consumer must wait one cycle for the load to reach WB.
  always_comb begin
    src_hit = (bus.id_uses_rs && (bus.id_rs == ex_q.base.dest)) ||
              (bus.id_uses_rt && (bus.id_rt == ex_q.base.dest));
    stall   = bus.id_valid && !bus.ex_flush && ex_q.base.valid &&
              ex_q.base.memread && (ex_q.base.dest != '0) && src_hit;
  end

  always_comb begin
    ex_d = '0;
    if (bus.id_valid && !stall && !bus.ex_flush) begin
      ex_d.base.valid    = 1'b1;
      ex_d.base.dest     = bus.id_dest;
      ex_d.base.regwrite = bus.id_regwrite;
      ex_d.base.memread  = bus.id_memread;
      ex_d.rs            = bus.id_rs;
      ex_d.rt            = bus.id_rt;
      ex_d.uses_rs       = bus.id_uses_rs;
      ex_d.uses_rt       = bus.id_uses_rt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_q  <= '0;
      mem_q <= '0;
      wb_q  <= '0;
    end else begin
      ex_q  <= ex_d;
      mem_q <= ex_q.base;
      wb_q  <= mem_q;
    end
  end

  assign op_src  = {ex_q.rt, ex_q.rs};
  assign op_uses = {ex_q.uses_rt, ex_q.uses_rs};

  for (genvar g = 0; g < NUM_OPS; g++) begin : g_op
    hfu_fwd_cmp u_cmp (
      .mem  (mem_q),
      .wb   (wb_q),
      .src  (op_src[g]),
      .uses (op_uses[g]),
      .sel  (op_sel[g])
    );
  end

  assign bus.fwd_a_sel       = op_sel[0];
  assign bus.fwd_b_sel       = op_sel[1];
  assign bus.pc_write_en     = !stall;
  assign bus.ifid_write_en   = !stall;
  assign bus.ctrl_bubble_sel = stall || bus.ex_flush;

`ifdef HFU_STALL_CNT_EN
  logic [31:0] stall_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      stall_cnt_q <= '0;
    else if (stall && (stall_cnt_q != 32'hFFFF_FFFF))
      stall_cnt_q <= stall_cnt_q + 32'd1;
  end

  assign bus.stall_cnt = stall_cnt_q;
`else
  assign bus.stall_cnt = '0;
`endif
endmodule

// File: tb/tb_hazard_forward_unit.sv
// Directed bench for hazard_forward_unit; per-cycle expectations are queued
// when ID is driven and popped at the following negedge.
module tb_hazard_forward_unit;
  import hazard_forward_unit_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  hazard_forward_unit_if bus ();

  hazard_forward_unit dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    int         tag;
    logic [1:0] a;
    logic [1:0] b;
    logic       stall;
    logic       bub;
  } exp_t;

  exp_t        sb[$];
  int          total = 0;
  int          bad = 0;
  int          step_no = 0;
  logic [31:0] exp_cnt = '0;

  task automatic chk(string name, int tag, logic [31:0] obs, logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s step=%0d got=%0h want=%0h", name, tag, obs, exp);
    end
  endtask

  task automatic drv(logic v, int rs, int rt, logic urs, logic urt, int dest,
                     logic rw, logic mr, logic fl);
    bus.id_valid    = v;
    bus.id_rs       = reg_idx_t'(rs);
    bus.id_rt       = reg_idx_t'(rt);
    bus.id_uses_rs  = urs;
    bus.id_uses_rt  = urt;
    bus.id_dest     = reg_idx_t'(dest);
    bus.id_regwrite = rw;
    bus.id_memread  = mr;
    bus.ex_flush    = fl;
  endtask

  task automatic nop();
    drv(1'b0, 0, 0, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic chk_idle(int tag);
    chk("rst_fwd_a", tag, 32'(bus.fwd_a_sel), 32'(FWD_NONE));
    chk("rst_fwd_b", tag, 32'(bus.fwd_b_sel), 32'(FWD_NONE));
    chk("rst_pc_we", tag, 32'(bus.pc_write_en), 32'd1);
    chk("rst_ifid_we", tag, 32'(bus.ifid_write_en), 32'd1);
    chk("rst_bubble", tag, 32'(bus.ctrl_bubble_sel), 32'd0);
    chk("rst_stall_cnt", tag, bus.stall_cnt, 32'd0);
  endtask

  // Queue this cycle's expectation, compare at negedge, then advance.
  task automatic step(logic [1:0] a, logic [1:0] b, logic stall, logic bub);
    exp_t e;
    sb.push_back('{step_no, a, b, stall, bub});
    @(negedge clk);
    if (sb.size() == 0) begin
      total++;
      bad++;
      $error("FAIL scoreboard_empty step=%0d got=0 want=1", step_no);
    end else begin
      e = sb.pop_front();
      chk("fwd_a", e.tag, 32'(bus.fwd_a_sel), 32'(e.a));
      chk("fwd_b", e.tag, 32'(bus.fwd_b_sel), 32'(e.b));
      chk("pc_we", e.tag, 32'(bus.pc_write_en), 32'(!e.stall));
      chk("ifid_we", e.tag, 32'(bus.ifid_write_en), 32'(!e.stall));
      chk("bubble", e.tag, 32'(bus.ctrl_bubble_sel), 32'(e.bub));
      chk("stall_cnt", e.tag, bus.stall_cnt, exp_cnt);
`ifdef HFU_STALL_CNT_EN
      if (e.stall && (exp_cnt != 32'hFFFF_FFFF)) exp_cnt = exp_cnt + 32'd1;
`endif
    end
    @(posedge clk);
    #1;
    step_no++;
  endtask

  task automatic drain();
    repeat (3) begin
      nop();
      step(FWD_NONE, FWD_NONE, 1'b0, 1'b0);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    nop();
    #3;
    chk_idle(-1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // add $3 ; sub $7,$3,$5 -> sub gets EX/MEM on A
    drv(1, 1, 2, 1, 1, 3, 1, 0, 0); step(FWD_NONE, FWD_NONE, 0, 0);
    drv(1, 3, 5, 1, 1, 7, 1, 0, 0); step(FWD_NONE, FWD_NONE, 0, 0);
    nop();                          step(FWD_EXMEM, FWD_NONE, 0, 0);
    drain();

    // add $3 ; nop ; or $8,$6,$3 -> MEM/WB on B
    drv(1, 1, 2, 1, 1, 3, 1, 0, 0); step(FWD_NONE, FWD_NONE, 0, 0);
    nop();                          step(FWD_NONE, FWD_NONE, 0, 0);
    drv(1, 6, 3, 1, 1, 8, 1, 0, 0); step(FWD_NONE, FWD_NONE, 0, 0);
    nop();                          step(FWD_NONE, FWD_MEMWB, 0, 0);
    drain();

    // two producers of $3 back to back: the younger (in MEM) wins
    drv(1, 1, 2, 1, 1, 3, 1, 0, 0); step(FWD_NONE, FWD_NONE, 0, 0);
    drv(1, 1, 2, 1, 1, 3, 1, 0, 0); step(FWD_NONE, FWD_NONE, 0, 0);
    drv(1, 3, 3, 1, 1, 12, 1, 0, 0); step(FWD_NONE, FWD_NONE, 0, 0);
    nop();                           step(FWD_EXMEM, FWD_EXMEM, 0, 0);
    drain();

    // lw $4 ; add $9,$4,$2 -> one stall cycle, then MEM/WB on A
    drv(1, 1, 0, 1, 0, 4, 1, 1, 0); step(FWD_NONE, FWD_NONE, 0, 0);
    drv(1, 4, 2, 1, 1, 9, 1, 0, 0); step(FWD_NONE, FWD_NONE, 1, 1);
    drv(1, 4, 2, 1, 1, 9, 1, 0, 0); step(FWD_NONE, FWD_NONE, 0, 0);
    nop();                          step(FWD_MEMWB, FWD_NONE, 0, 0);
    drain();

    // $0 is never a forwarding or stall source
    drv(1, 1, 2, 1, 1, 0, 1, 0, 0);  step(FWD_NONE, FWD_NONE, 0, 0);
    drv(1, 0, 0, 1, 1, 10, 1, 0, 0); step(FWD_NONE, FWD_NONE, 0, 0);
    nop();                           step(FWD_NONE, FWD_NONE, 0, 0);
    nop();                           step(FWD_NONE, FWD_NONE, 0, 0);
    drv(1, 1, 0, 1, 0, 0, 1, 1, 0);  step(FWD_NONE, FWD_NONE, 0, 0);
    drv(1, 0, 0, 1, 1, 10, 1, 0, 0); step(FWD_NONE, FWD_NONE, 0, 0);
    drain();

    // lw $5 ; lw $9,($5) flushed ; add reading $9 must not stall
    drv(1, 1, 0, 1, 0, 5, 1, 1, 0);  step(FWD_NONE, FWD_NONE, 0, 0);
    drv(1, 5, 0, 1, 0, 9, 1, 1, 1);  step(FWD_NONE, FWD_NONE, 0, 1);
    drv(1, 9, 9, 1, 1, 11, 1, 0, 0); step(FWD_NONE, FWD_NONE, 0, 0);
    nop();                           step(FWD_NONE, FWD_NONE, 0, 0);
    drain();

    // reset asserted in the middle of a stall cycle
    drv(1, 1, 0, 1, 0, 4, 1, 1, 0); step(FWD_NONE, FWD_NONE, 0, 0);
    drv(1, 4, 2, 1, 1, 9, 1, 0, 0);
    #1;
    chk("mid_stall_pc_we", step_no, 32'(bus.pc_write_en), 32'd0);
    chk("mid_stall_bubble", step_no, 32'(bus.ctrl_bubble_sel), 32'd1);
    rst_n = 1'b0;
    #1;
    chk_idle(step_no);
    exp_cnt = '0;
    rst_n = 1'b1;
    step(FWD_NONE, FWD_NONE, 0, 0);
    drain();

    // three separate load-use stalls
    repeat (3) begin
      drv(1, 1, 0, 1, 0, 4, 1, 1, 0); step(FWD_NONE, FWD_NONE, 0, 0);
      drv(1, 2, 4, 1, 1, 9, 1, 0, 0); step(FWD_NONE, FWD_NONE, 1, 1);
      drv(1, 2, 4, 1, 1, 9, 1, 0, 0); step(FWD_NONE, FWD_NONE, 0, 0);
      nop();                          step(FWD_NONE, FWD_MEMWB, 0, 0);
      drain();
    end
`ifdef HFU_STALL_CNT_EN
    chk("stall_cnt_three", step_no, bus.stall_cnt, 32'd3);
`else
    chk("stall_cnt_tied", step_no, bus.stall_cnt, 32'd0);
`endif

    chk("scoreboard_drained", step_no, 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
